// File: rtl/md_sequencer.sv
// md_sequencer: multiply/divide sequencer that owns the HI/LO registers.
// An E-stage mult/div computes its 64-bit result at issue. The result sits
// in a pending register for N busy cycles, then commits to HI/LO.
// mthi/mtlo write HI/LO directly. While an operation runs, a younger
// HI/LO-dependent instruction in D is stalled.
module md_sequencer #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_req_d,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        issue_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [63:0] pend, result;
  logic        commit;
  logic        is_md, accept_md, accept_mthi, accept_mtlo;

  // op 0..3 is the mult/div family (op[2] clear); 6/7 fall through everywhere
  assign is_md       = start & ~op[2];
  assign accept_md   = (state == IDLE) & is_md;
  assign accept_mthi = (state == IDLE) & start & (op == 3'd4);
  assign accept_mtlo = (state == IDLE) & start & (op == 3'd5);

  assign busy  = (state == RUN);
  assign stall = hilo_req_d & (busy | is_md);

  // ---------------- arithmetic ----------------
  logic [63:0] smul, umul;
  logic [31:0] ma, mb, sdiv_d, sq_mag, sr_mag, sq, sr;
  logic [31:0] udiv_d, uq, ur;

  // Products: the low 64 bits of a sign-extended multiply are the signed product
  assign smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign umul = {32'd0, a} * {32'd0, b};

  // Signed divide via magnitudes. Divisors are forced nonzero so the
  // datapath never divides by zero; the b==0 result is selected below.
  // 0x80000000 / -1 yields magnitude 0x80000000 with a positive sign, i.e.
  // quotient 0x80000000 and remainder 0. This is the required wrap.
  assign ma     = a[31] ? (~a + 32'd1) : a;
  assign mb     = b[31] ? (~b + 32'd1) : b;
  assign sdiv_d = (mb == 32'd0) ? 32'd1 : mb;
  assign sq_mag = ma / sdiv_d;
  assign sr_mag = ma % sdiv_d;
  assign sq     = (a[31] ^ b[31]) ? (~sq_mag + 32'd1) : sq_mag;
  assign sr     = a[31] ? (~sr_mag + 32'd1) : sr_mag;

  assign udiv_d = (b == 32'd0) ? 32'd1 : b;
  assign uq     = a / udiv_d;
  assign ur     = a % udiv_d;

  // Select the {hi,lo} image for the issuing op
  always_comb begin
    result = '0;
    case (op[1:0])
      2'd0: result = smul;
      2'd1: result = umul;
      2'd2: result = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {sr, sq};
      default: result = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {ur, uq};
    endcase
  end

  // ---------------- control ----------------
  // Next-state: IDLE loads the cycle count, RUN counts down and commits at 1
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (accept_md) begin
          state_nxt = RUN;
          cnt_nxt   = op[1] ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
        end
      end
      RUN: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          commit    = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Pending result captured at issue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         pend <= '0;
    else if (accept_md) pend <= result;
  end

  // HI/LO architectural registers: commit or direct move
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= pend[63:32];
      lo <= pend[31:0];
    end else if (accept_mthi) begin
      hi <= a;
    end else if (accept_mtlo) begin
      lo <= a;
    end
  end

  // Sticky flag for any issue attempt during RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       issue_err <= 1'b0;
    else if (start && state == RUN)   issue_err <= 1'b1;
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer. Stimulus pushes expected {hi,lo,busy
// length} for each mult/div. A monitor pops and compares when busy falls.
module tb_md_sequencer;
  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk, reset, start, hilo_req_d;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, stall, issue_err;

  md_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hilo_req_d(hilo_req_d), .hi(hi), .lo(lo), .busy(busy), .stall(stall),
    .issue_err(issue_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] hi; logic [31:0] lo; int n; } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] pend_model = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference arithmetic with 64-bit integer math
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = longint'(x);           uy = longint'(y);
    case (o)
      3'd0: return 64'(sx * sy);
      3'd1: return 64'(ux * uy);
      3'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy; r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        uq = ux / uy; ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Drive one issue cycle from IDLE. The stall check covers the issue cycle T.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    if (o <= 3'd3) begin
      pend_model = model(o, x, y);
      e.hi = pend_model[63:32]; e.lo = pend_model[31:0];
      e.n  = o[1] ? DIV_N : MUL_N;
      sbq.push_back(e);
    end else if (o == 3'd4) m_hi = x;
    else if (o == 3'd5) m_lo = x;
    @(negedge clk);
    chk("stall_issue", stall, hilo_req_d & (o <= 3'd3));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for commit (bounded). Check stall while busy and after commit.
  task automatic wait_done();
    bit done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin done = 1; break; end
      chk("stall_busy", stall, hilo_req_d);
    end
    if (!done) begin
      errors++;
      $display("FAIL busy_timeout actual=busy expected=idle");
    end
    chk("stall_after", stall, 1'b0);
    {m_hi, m_lo} = pend_model;
  endtask

  task automatic chk_regs(input string nm);
    @(negedge clk);
    chk({nm, "_hi"}, hi, m_hi);
    chk({nm, "_lo"}, lo, m_lo);
    chk({nm, "_busy"}, busy, 1'b0);
  endtask

  // Monitor: count busy cycles, then compare on busy falling
  initial begin
    int  bcnt = 0;
    bit  pbusy = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        bcnt = 0; pbusy = 0;
      end else begin
        if (busy) bcnt++;
        else if (pbusy) begin
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_empty actual=commit expected=none");
          end else begin
            e = sbq.pop_front();
            chk("sb_hi", hi, e.hi);
            chk("sb_lo", lo, e.lo);
            chk("sb_busy_cycles", bcnt, e.n);
          end
          bcnt = 0;
        end
        pbusy = busy;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] o;
    logic [31:0] x, y;
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; hilo_req_d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0); chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0); chk("rst_err", issue_err, 0);
    @(negedge clk) reset = 1'b1;

    // Reset in the middle of a divide
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    sbq.delete(); m_hi = '0; m_lo = '0;
    #1;
    chk("midrst_hi", hi, 0); chk("midrst_lo", lo, 0);
    chk("midrst_busy", busy, 0); chk("midrst_err", issue_err, 0);
    @(negedge clk) reset = 1'b1;
    issue(3'd0, 32'd6, 32'd7); wait_done();
    chk("post_rst_lo", lo, 32'd42);

    // Directed arithmetic
    issue(3'd0, 32'hFFFF_FFFE, 32'd3); wait_done();
    chk("mult_hi", hi, 32'hFFFF_FFFF); chk("mult_lo", lo, 32'hFFFF_FFFA);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
    chk("multu_hi", hi, 32'hFFFF_FFFE); chk("multu_lo", lo, 32'h1);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2); wait_done();
    chk("div_hi", hi, 32'hFFFF_FFFF); chk("div_lo", lo, 32'hFFFF_FFFD);
    issue(3'd2, 32'hFFFF_FFF9, 32'd0); wait_done();
    chk("div0_hi", hi, 32'hFFFF_FFF9); chk("div0_lo", lo, 32'hFFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
    chk("ovf_hi", hi, 32'h0); chk("ovf_lo", lo, 32'h8000_0000);
    issue(3'd3, 32'd17, 32'd0); wait_done();
    chk("divu0_hi", hi, 32'd17); chk("divu0_lo", lo, 32'hFFFF_FFFF);

    // mthi in IDLE with a D-stage HI/LO user
    hilo_req_d = 1'b1;
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    @(negedge clk);
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_busy", busy, 0); chk("mthi_stall", stall, 0);
    hilo_req_d = 1'b0;

    // Randomized mix
    for (int k = 0; k < 60; k++) begin
      o = 3'($urandom_range(0, 7));
      x = pick(); y = pick();
      hilo_req_d = 1'($urandom_range(0, 1));
      issue(o, x, y);
      if (o <= 3'd3) wait_done();
      else chk_regs("rnd");
    end
    chk("err_clear", issue_err, 0);

    // Stall across a divide, with an ignored mtlo issued mid-run
    hilo_req_d = 1'b1;
    issue(3'd2, 32'd1000, 32'd3);
    x = m_lo;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd5; a = 32'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("ign_err", issue_err, 1);
    chk("ign_lo", lo, x);
    chk("ign_stall", stall, 1);
    wait_done();
    chk("ign_div_lo", lo, 32'd333);
    chk("ign_div_hi", hi, 32'd1);
    hilo_req_d = 1'b0;
    chk_regs("after_ign");
    chk("err_sticky", issue_err, 1);

    @(negedge clk) reset = 1'b0;
    #1 chk("final_rst_err", issue_err, 0);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
